// File: rtl/apb_timer_mc.sv
// apb_timer_mc: N_CH independent prescaled up-counters with compare/overflow
// flags behind a zero-wait-state APB slave; one level interrupt per channel.
module apb_timer_mc #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_CH = 4,
  parameter int CNT_WIDTH = 32,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [N_CH-1:0]           irq_o
);
  logic [3:0] ch;
  logic [1:0] rsel;
  logic err, acc, wr, unused;
  logic [31:0] rd [N_CH];
  assign ch = PADDR[7:4];
  assign rsel = PADDR[3:2];
  assign err = (int'(ch) >= N_CH) || (PADDR[1:0] != 2'b0) || ((PADDR >> 8) != '0);
  assign acc = PSEL & PENABLE;
  assign wr = acc & PWRITE & ~err;
  assign unused = ^PWDATA;
  assign PREADY = 1'b1;
  assign PSLVERR = acc & err;
  always_comb begin
    PRDATA = '0;
    for (int k = 0; k < N_CH; k++)
      if (acc && !err && ch == 4'(k)) PRDATA = rd[k];
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt, cmp;
    logic [PRESC_WIDTH-1:0] presc, pcnt;
    logic en, oneshot, ie_cmp, ie_ovf, cmpf, ovff;
    logic sel, wr_cnt, wr_ctrl, wr_cmp, wr_stat, tick, hit;
    assign sel = wr && ch == 4'(i);
    assign wr_cnt = sel && rsel == 2'd0;
    assign wr_ctrl = sel && rsel == 2'd1;
    assign wr_cmp = sel && rsel == 2'd2;
    assign wr_stat = sel && rsel == 2'd3;
    // a software COUNT write swallows a coincident tick entirely
    assign tick = en && pcnt == presc && !wr_cnt;
    assign hit = tick && cnt == cmp;
    always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
        cnt <= '0;
        cmp <= '0;
        presc <= '0;
        pcnt <= '0;
        en <= 1'b0;
        oneshot <= 1'b0;
        ie_cmp <= 1'b0;
        ie_ovf <= 1'b0;
        cmpf <= 1'b0;
        ovff <= 1'b0;
      end else begin
        pcnt <= (!en || wr_cnt || wr_ctrl || tick) ? '0 : pcnt + 1'b1;
        if (wr_cnt) cnt <= PWDATA[CNT_WIDTH-1:0];
        else if (tick) cnt <= hit ? '0 : cnt + 1'b1;
        if (wr_cmp) cmp <= PWDATA[CNT_WIDTH-1:0];
        if (wr_ctrl) {presc, ie_ovf, ie_cmp, oneshot, en} <= {PWDATA[8+:PRESC_WIDTH], PWDATA[3:0]};
        else if (hit && oneshot) en <= 1'b0;
        cmpf <= hit | (cmpf & ~(wr_stat & PWDATA[0]));
        ovff <= (tick && !hit && &cnt) | (ovff & ~(wr_stat & PWDATA[1]));
      end
    assign irq_o[i] = (cmpf & ie_cmp) | (ovff & ie_ovf);
    assign rd[i] = rsel == 2'd0 ? 32'(cnt) :
                   rsel == 2'd1 ? 32'({presc, 4'b0, ie_ovf, ie_cmp, oneshot, en}) :
                   rsel == 2'd2 ? 32'(cmp) : {30'b0, ovff, cmpf};
  end
endmodule

// File: tb/tb_apb_timer_mc.sv
// tb_apb_timer_mc: register-map vector table plus cycle-exact sequences for
// periodic, prescaled, one-shot, overflow, contention and async reset.
module tb_apb_timer_mc;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic pwrite = 1'b0, psel = 1'b0, psel8 = 1'b0, penable = 1'b0;
  logic [31:0] prdata, prdata8;
  logic pready, pready8, pslverr, pslverr8;
  logic [3:0] irq;
  logic [0:0] irq8;
  int checks = 0, failures = 0;

  apb_timer_mc dut (
    .HCLK(clk), .HRESETn(rst_n), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel), .PENABLE(penable), .PRDATA(prdata), .PREADY(pready),
    .PSLVERR(pslverr), .irq_o(irq)
  );
  apb_timer_mc #(.N_CH(1), .CNT_WIDTH(8)) dut8 (
    .HCLK(clk), .HRESETn(rst_n), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel8), .PENABLE(penable), .PRDATA(prdata8), .PREADY(pready8),
    .PSLVERR(pslverr8), .irq_o(irq8)
  );

  typedef struct {
    bit s;
    logic [11:0] addr;
    logic [31:0] wdata;
    bit write;
    logic [31:0] rdata;
    bit err;
  } vec_t;
  vec_t tv[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic acc(input bit s, input logic [11:0] a, input logic [31:0] d, input bit w,
                     output logic [31:0] r, output logic e);
    psel = !s; psel8 = s; paddr = a; pwdata = d; pwrite = w; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1;
    r = s ? prdata8 : prdata;
    e = s ? pslverr8 : pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; psel8 = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input bit s, input logic [11:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    acc(s, a, d, 1'b1, r, e);
  endtask

  task automatic rdc(input string name, input bit s, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic e;
    acc(s, a, 32'h0, 1'b0, r, e);
    chk(name, r, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0};
    tv[1]  = '{1'b0, 12'h004, 32'h0, 1'b0, 32'h0, 1'b0};
    tv[2]  = '{1'b0, 12'h008, 32'h0, 1'b0, 32'h0, 1'b0};
    tv[3]  = '{1'b0, 12'h00C, 32'h0, 1'b0, 32'h0, 1'b0};
    tv[4]  = '{1'b0, 12'h038, 32'h12345678, 1'b1, 32'h0, 1'b0};
    tv[5]  = '{1'b0, 12'h038, 32'h0, 1'b0, 32'h12345678, 1'b0};
    tv[6]  = '{1'b0, 12'h034, 32'hFFFFFFFE, 1'b1, 32'h0, 1'b0};
    tv[7]  = '{1'b0, 12'h034, 32'h0, 1'b0, 32'h0000FF0E, 1'b0};
    tv[8]  = '{1'b0, 12'h030, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0};
    tv[9]  = '{1'b0, 12'h030, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0};
    tv[10] = '{1'b0, 12'h048, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1};
    tv[11] = '{1'b0, 12'h048, 32'h0, 1'b0, 32'h0, 1'b1};
    tv[12] = '{1'b0, 12'h005, 32'h0, 1'b0, 32'h0, 1'b1};
    tv[13] = '{1'b0, 12'h138, 32'h0, 1'b1, 32'h0, 1'b1};
    tv[14] = '{1'b0, 12'h138, 32'h0, 1'b0, 32'h0, 1'b1};
    tv[15] = '{1'b0, 12'h038, 32'h0, 1'b0, 32'h12345678, 1'b0};
    tv[16] = '{1'b0, 12'h03C, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0};
    tv[17] = '{1'b0, 12'h03C, 32'h0, 1'b0, 32'h0, 1'b0};
    tv[18] = '{1'b1, 12'h008, 32'h000001FF, 1'b1, 32'h0, 1'b0};
    tv[19] = '{1'b1, 12'h008, 32'h0, 1'b0, 32'h000000FF, 1'b0};
    tv[20] = '{1'b1, 12'h010, 32'h0, 1'b0, 32'h0, 1'b1};

    cyc(2);
    chk("rst_pready", 32'({pready, pready8}), 32'h3);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    for (int i = 0; i < 21; i++) begin
      logic [31:0] r;
      logic e;
      acc(tv[i].s, tv[i].addr, tv[i].wdata, tv[i].write, r, e);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(tv[i].err));
      if (!tv[i].write) chk($sformatf("vec%0d_rdata", i), r, tv[i].rdata);
    end

    // periodic, PRESC=0, CMP=1
    wr(0, 12'h008, 32'd1);
    wr(0, 12'h004, 32'h5);
    chk("basic_t0", 32'(irq[0]), 32'h0);
    cyc(1);
    chk("basic_t1", 32'(irq[0]), 32'h0);
    cyc(1);
    chk("basic_t2", 32'(irq[0]), 32'h1);
    cyc(3);
    chk("basic_hold", 32'(irq[0]), 32'h1);
    wr(0, 12'h004, 32'h4);
    wr(0, 12'h00C, 32'h1);
    chk("basic_w1c", 32'(irq[0]), 32'h0);
    rdc("basic_status", 0, 12'h00C, 32'h0);

    // prescaler 3, CMP=2: period 12
    wr(0, 12'h018, 32'd2);
    wr(0, 12'h014, 32'h305);
    cyc(11);
    chk("presc_t11", 32'(irq[1]), 32'h0);
    cyc(1);
    chk("presc_t12", 32'(irq[1]), 32'h1);
    cyc(5);
    wr(0, 12'h014, 32'h300);
    rdc("presc_count", 0, 12'h010, 32'd1);
    rdc("presc_ctrl", 0, 12'h014, 32'h300);
    wr(0, 12'h01C, 32'h3);

    // one-shot, CMP=5
    wr(0, 12'h028, 32'd5);
    wr(0, 12'h024, 32'h7);
    cyc(5);
    chk("os_t5", 32'(irq[2]), 32'h0);
    cyc(1);
    chk("os_t6", 32'(irq[2]), 32'h1);
    rdc("os_ctrl", 0, 12'h024, 32'h6);
    cyc(10);
    rdc("os_count", 0, 12'h020, 32'h0);
    rdc("os_status", 0, 12'h02C, 32'h1);

    // W1C coinciding with a compare hit; COUNT write coinciding with a tick
    wr(0, 12'h000, 32'h0);
    wr(0, 12'h00C, 32'h3);
    wr(0, 12'h004, 32'h5);
    wr(0, 12'h00C, 32'h1);
    chk("w1c_t1", 32'(irq[0]), 32'h0);
    wr(0, 12'h00C, 32'h1);
    chk("w1c_set_wins", 32'(irq[0]), 32'h1);
    wr(0, 12'h000, 32'h100);
    rdc("cnt_write_wins", 0, 12'h000, 32'h100);
    wr(0, 12'h004, 32'h0);
    wr(0, 12'h00C, 32'h3);

    // 8-bit overflow: COUNT above CMP runs to wrap
    wr(1, 12'h008, 32'h10);
    wr(1, 12'h000, 32'h20);
    wr(1, 12'h004, 32'h9);
    cyc(223);
    chk("ovf_t223", 32'(irq8), 32'h0);
    cyc(1);
    chk("ovf_t224", 32'(irq8), 32'h1);
    rdc("ovf_status", 1, 12'h00C, 32'h2);
    rdc("ovf_count", 1, 12'h000, 32'h1);

    // asynchronous reset mid-count
    wr(0, 12'h018, 32'd3);
    wr(0, 12'h014, 32'h5);
    cyc(6);
    chk("pre_reset_irq", 32'(irq[1]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_irq", 32'(irq), 32'h0);
    chk("async_irq8", 32'(irq8), 32'h0);
    chk("async_pready", 32'(pready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    rdc("rst_count1", 0, 12'h010, 32'h0);
    rdc("rst_ctrl1", 0, 12'h014, 32'h0);
    rdc("rst_cmp1", 0, 12'h018, 32'h0);
    rdc("rst_cmp3", 0, 12'h038, 32'h0);
    cyc(5);
    rdc("rst_no_restart", 0, 12'h010, 32'h0);
    rdc("rst_count8", 1, 12'h000, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
